// File: rtl/rf_arb_pkg.sv
// Shared constants and sizing helper for the register-file port arbiter.
// The RF_WRITE_PRIORITY_EN build option is consumed by regfile_port_arbiter.
package rf_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ID_W_DEF   = 4;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Never returns less than 1 so that a 2-entry pointer still gets one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side and register-file-side signals of the port arbiter.
// The slave modport is the arbiter; master is the surrounding decode/writeback logic plus register file.
interface regfile_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 4
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ID_W-1:0]   req_id;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    logic                      rf_rd;
    logic                      rf_wn;
    logic [ID_W-1:0]           rf_reg_id;
    logic [DATA_W-1:0]         rf_write_data;
    logic [DATA_W-1:0]         rf_read_data;

    modport master (
        output req, req_we, req_id, req_wdata, rf_read_data,
        input  gnt, rvalid, rdata, rf_rd, rf_wn, rf_reg_id, rf_write_data
    );

    modport slave (
        input  req, req_we, req_id, req_wdata, rf_read_data,
        output gnt, rvalid, rdata, rf_rd, rf_wn, rf_reg_id, rf_write_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
// Outputs a one-hot grant and the encoded winner index.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter  int N     = 3,
    localparam int PTR_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] winner
);

    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N);

    always_comb begin
        logic           found;
        logic [PTR_W:0] idx;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= N_W) idx = idx - N_W;
            if (!found && req[idx[PTR_W-1:0]]) begin
                found                 = 1'b1;
                gnt[idx[PTR_W-1:0]]   = 1'b1;
                winner                = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin sharing of the single register-file port among NUM_REQ requesters, read data returned one cycle later.
// Build option RF_WRITE_PRIORITY_EN: pending writers win over all readers.
module regfile_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input logic                  clk,
    input logic                  rst,
    regfile_port_arbiter_if.slave bus
);

    localparam int             PTR_W = clog2(NUM_REQ);
    localparam logic [PTR_W:0] N_W   = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W:0]     ptr_inc;
    logic [PTR_W-1:0]   winner;
    logic               pend_vld;
    logic [PTR_W-1:0]   pend_tag;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] gnt_i;
    logic               grant;
    logic               sel_we;
    logic [ID_W-1:0]    sel_id;
    logic [DATA_W-1:0]  sel_wdata;
    logic               issue_rd;
    logic               issue_wr;
    logic               ret_vld;

`ifdef RF_WRITE_PRIORITY_EN
    logic [NUM_REQ-1:0] wr_req;
    assign wr_req  = bus.req & bus.req_we;
    assign arb_req = (|wr_req) ? wr_req : bus.req;
`else
    assign arb_req = bus.req;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (arb_req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    // No access may reach the register file while reset is held.
    assign gnt_i = rst ? '0 : arb_gnt;
    assign grant = |gnt_i;

    always_comb begin
        sel_we    = 1'b0;
        sel_id    = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_i[i]) begin
                sel_we    = sel_we | bus.req_we[i];
                sel_id    = sel_id | bus.req_id[i*ID_W +: ID_W];
                sel_wdata = sel_wdata | bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign issue_rd = grant && (sel_we == OP_RD);
    assign issue_wr = grant && (sel_we == OP_WR);

    assign bus.gnt           = gnt_i;
    assign bus.rf_rd         = issue_rd;
    assign bus.rf_wn         = issue_wr;
    assign bus.rf_reg_id     = sel_id;
    assign bus.rf_write_data = issue_wr ? sel_wdata : '0;

    assign ptr_inc  = {1'b0, winner} + (PTR_W+1)'(1);
    assign ptr_next = (ptr_inc == N_W) ? '0 : ptr_inc[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            pend_vld <= 1'b0;
            pend_tag <= '0;
        end else begin
            if (grant) ptr <= ptr_next;
            pend_vld <= issue_rd;
            if (issue_rd) pend_tag <= winner;
        end
    end

    // A read in flight when reset arrives is dropped rather than returned.
    assign ret_vld = pend_vld && !rst;

    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rvalid[i] = ret_vld && (pend_tag == PTR_W'(i));
        end
    end

    assign bus.rdata = ret_vld ? bus.rf_read_data : '0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 16x16 register file (registered read).
// Expected values are hand-computed; the priority scenario follows RF_WRITE_PRIORITY_EN.
module tb_regfile_port_arbiter;

    localparam int NR = 3;
    localparam int DW = 16;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

    regfile_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [16];
    logic [DW-1:0] rf_q = '0;

    always @(posedge clk) begin
        if (bus.rf_wn) mem[bus.rf_reg_id] <= bus.rf_write_data;
        if (bus.rf_rd) rf_q <= mem[bus.rf_reg_id];
    end
    assign bus.rf_read_data = rf_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_id    = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_rq(input int i, input logic r, input logic we,
                          input logic [IW-1:0] id, input logic [DW-1:0] wd);
        bus.req[i]                 = r;
        bus.req_we[i]              = we;
        bus.req_id[i*IW +: IW]     = id;
        bus.req_wdata[i*DW +: DW]  = wd;
    endtask

    initial begin
        // reset: requests present but nothing may be granted
        idle();
        set_rq(0, 1'b1, 1'b0, 4'd1, 16'h0);
        set_rq(1, 1'b1, 1'b1, 4'd2, 16'h1234);
        set_rq(2, 1'b1, 1'b0, 4'd3, 16'h0);
        tick();
        #4;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rd", 32'(bus.rf_rd), 32'h0);
        chk("rst_wn", 32'(bus.rf_wn), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        #4;
        chk("idle_gnt", 32'(bus.gnt), 32'h0);
        chk("idle_rd", 32'(bus.rf_rd), 32'h0);
        chk("idle_wn", 32'(bus.rf_wn), 32'h0);
        chk("idle_rvalid", 32'(bus.rvalid), 32'h0);
        chk("idle_rdata", 32'(bus.rdata), 32'h0);
        chk("idle_id", 32'(bus.rf_reg_id), 32'h0);
        chk("idle_wdata", 32'(bus.rf_write_data), 32'h0);
        tick();

        // requester 2 writes id5, then requester 0 reads it back
        set_rq(2, 1'b1, 1'b1, 4'd5, 16'hBEEF);
        #4;
        chk("wr_gnt", 32'(bus.gnt), 32'b100);
        chk("wr_wn", 32'(bus.rf_wn), 32'h1);
        chk("wr_rd", 32'(bus.rf_rd), 32'h0);
        chk("wr_id", 32'(bus.rf_reg_id), 32'h5);
        chk("wr_wdata", 32'(bus.rf_write_data), 32'hBEEF);
        tick();
        idle();
        set_rq(0, 1'b1, 1'b0, 4'd5, 16'h0);
        #4;
        chk("rd_gnt", 32'(bus.gnt), 32'b001);
        chk("rd_rd", 32'(bus.rf_rd), 32'h1);
        chk("rd_wn", 32'(bus.rf_wn), 32'h0);
        chk("rd_id", 32'(bus.rf_reg_id), 32'h5);
        chk("rd_rvalid_pre", 32'(bus.rvalid), 32'h0);
        tick();
        idle();
        #4;
        chk("wr_rd_rvalid", 32'(bus.rvalid), 32'b001);
        chk("wr_rd_rdata", 32'(bus.rdata), 32'hBEEF);
        chk("wr_rd_gnt", 32'(bus.gnt), 32'h0);
        tick();

        // preload ids 0..3 with 0x10..0x13 through requester 1
        for (int k = 0; k < 4; k++) begin
            idle();
            set_rq(1, 1'b1, 1'b1, 4'(k), 16'h10 + 16'(k));
            #4;
            chk("pre_gnt", 32'(bus.gnt), 32'b010);
            chk("pre_wdata", 32'(bus.rf_write_data), 32'h10 + 32'(k));
            tick();
        end

        // requester 1 reads ids 0..3 back-to-back
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) set_rq(1, 1'b1, 1'b0, 4'(k), 16'h0);
            #4;
            if (k < 4) begin
                chk("b2b_gnt", 32'(bus.gnt), 32'b010);
                chk("b2b_id", 32'(bus.rf_reg_id), 32'(k));
            end
            if (k == 0) begin
                chk("b2b_rvalid0", 32'(bus.rvalid), 32'h0);
            end else begin
                chk("b2b_rvalid", 32'(bus.rvalid), 32'b010);
                chk("b2b_rdata", 32'(bus.rdata), 32'h10 + 32'(k - 1));
            end
            tick();
        end
        idle();
        #4;
        chk("b2b_done", 32'(bus.rvalid), 32'h0);
        tick();

        // read granted to requester 1, reset pulsed in the return cycle
        set_rq(1, 1'b1, 1'b0, 4'd2, 16'h0);
        #4;
        chk("rstrd_gnt", 32'(bus.gnt), 32'b010);
        tick();
        idle();
        rst = 1'b1;
        #4;
        chk("rstrd_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rstrd_rdata", 32'(bus.rdata), 32'h0);
        tick();
        rst = 1'b0;
        #4;
        chk("rstrd_after", 32'(bus.rvalid), 32'h0);
        tick();

        // three readers hold requests: order 0,1,2,0,1,2 starting from ptr 0
        set_rq(0, 1'b1, 1'b0, 4'd1, 16'h0);
        set_rq(1, 1'b1, 1'b0, 4'd2, 16'h0);
        set_rq(2, 1'b1, 1'b0, 4'd3, 16'h0);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) idle();
            #4;
            if (k < 6) chk("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 3)));
            else chk("rr_gnt_idle", 32'(bus.gnt), 32'h0);
            if (k == 0 || k == 7) begin
                chk("rr_rvalid0", 32'(bus.rvalid), 32'h0);
                chk("rr_rdata0", 32'(bus.rdata), 32'h0);
            end else begin
                chk("rr_rvalid", 32'(bus.rvalid), 32'(1 << ((k - 1) % 3)));
                chk("rr_rdata", 32'(bus.rdata), 32'h11 + 32'((k - 1) % 3));
            end
            tick();
        end

        // mixed readers and one writer with ptr at 0
        set_rq(0, 1'b1, 1'b0, 4'd1, 16'h0);
        set_rq(1, 1'b1, 1'b0, 4'd2, 16'h0);
        set_rq(2, 1'b1, 1'b1, 4'd7, 16'h0055);
`ifdef RF_WRITE_PRIORITY_EN
        #4;
        chk("pri_gnt1", 32'(bus.gnt), 32'b100);
        chk("pri_wn1", 32'(bus.rf_wn), 32'h1);
        chk("pri_wdata1", 32'(bus.rf_write_data), 32'h55);
        tick();
        set_rq(2, 1'b0, 1'b0, 4'd0, 16'h0);
        #4;
        chk("pri_gnt2", 32'(bus.gnt), 32'b001);
        chk("pri_rd2", 32'(bus.rf_rd), 32'h1);
        chk("pri_rvalid2", 32'(bus.rvalid), 32'h0);
        tick();
        set_rq(0, 1'b0, 1'b0, 4'd0, 16'h0);
        #4;
        chk("pri_gnt3", 32'(bus.gnt), 32'b010);
        chk("pri_rvalid3", 32'(bus.rvalid), 32'b001);
        chk("pri_rdata3", 32'(bus.rdata), 32'h11);
        tick();
        idle();
        #4;
        chk("pri_rvalid4", 32'(bus.rvalid), 32'b010);
        chk("pri_rdata4", 32'(bus.rdata), 32'h12);
        tick();
`else
        #4;
        chk("rr_mix_gnt1", 32'(bus.gnt), 32'b001);
        chk("rr_mix_rd1", 32'(bus.rf_rd), 32'h1);
        tick();
        set_rq(0, 1'b0, 1'b0, 4'd0, 16'h0);
        #4;
        chk("rr_mix_gnt2", 32'(bus.gnt), 32'b010);
        chk("rr_mix_rvalid2", 32'(bus.rvalid), 32'b001);
        chk("rr_mix_rdata2", 32'(bus.rdata), 32'h11);
        tick();
        set_rq(1, 1'b0, 1'b0, 4'd0, 16'h0);
        #4;
        chk("rr_mix_gnt3", 32'(bus.gnt), 32'b100);
        chk("rr_mix_wn3", 32'(bus.rf_wn), 32'h1);
        chk("rr_mix_wdata3", 32'(bus.rf_write_data), 32'h55);
        chk("rr_mix_rvalid3", 32'(bus.rvalid), 32'b010);
        chk("rr_mix_rdata3", 32'(bus.rdata), 32'h12);
        tick();
        idle();
        #4;
        chk("rr_mix_rvalid4", 32'(bus.rvalid), 32'h0);
        tick();
`endif

        // read back the register written by requester 2
        set_rq(0, 1'b1, 1'b0, 4'd7, 16'h0);
        #4;
        chk("rb_gnt", 32'(bus.gnt), 32'b001);
        tick();
        idle();
        #4;
        chk("rb_rvalid", 32'(bus.rvalid), 32'b001);
        chk("rb_rdata", 32'(bus.rdata), 32'h55);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single-port 16x16 register file among NUM_REQ requesters, for example operand-A read, operand-B read and writeback.
- Picks one request per cycle by round-robin and drives the register file's rd/wn/reg_id/write_data port.
- Returns the registered read data to the requester that issued the read.
- Sits between the decode/writeback logic and the register file.

Parameters:
- NUM_REQ, 3: number of requesters, legal range 2..8.
- DATA_W, 16: register data width.
- ID_W, 4: register index width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request.
- req_we  in  NUM_REQ  per-requester operation type: 1 = write, 0 = read.
- req_id  in  NUM_REQ*ID_W  packed register indices; requester i uses slice [i*ID_W +: ID_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant, combinational.
- rvalid  out  NUM_REQ  one-hot read-data-valid, registered.
- rdata  out  DATA_W  read data, shared by all requesters.
- rf_rd  out  1  register-file read strobe.
- rf_wn  out  1  register-file write strobe.
- rf_reg_id  out  ID_W  register-file index.
- rf_write_data  out  DATA_W  register-file write data.
- rf_read_data  in  DATA_W  register-file registered read data.

Behaviour:
- Reset (rst=1 at posedge):
  - ptr <= 0, pend_vld <= 0, pend_tag <= 0.
  - While rst is high, gnt=0 and rf_rd=rf_wn=0, so no register-file access is issued.
  - rvalid=0 in the cycle after reset.
  - Register-file contents are not reset.
- Arbitration (combinational):
  - Search req starting at index ptr and wrapping modulo NUM_REQ; the first set bit wins.
  - gnt is one-hot on the winner, or all zero if req==0.
- Issue, in the same cycle as the grant:
  - rf_reg_id = req_id[winner].
  - Read (req_we=0): rf_rd=1, rf_wn=0.
  - Write (req_we=1): rf_wn=1, rf_rd=0, rf_write_data = req_wdata[winner].
  - rf_rd and rf_wn are never both 1. When idle both are 0, and rf_reg_id/rf_write_data are 0.
- Pointer:
  - On any grant, ptr <= (winner+1) mod NUM_REQ.
  - When idle, ptr holds.
- Handshake:
  - A requester holds req and its fields stable until it sees gnt=1 in that cycle.
  - The request is consumed at that posedge. The requester may present a new request in the next cycle.
- Read return, latency 1:
  - A read granted in cycle N sets pend_vld=1 and pend_tag=winner at the posedge.
  - In cycle N+1, rvalid[pend_tag]=1 and rdata = rf_read_data (passthrough).
  - A write grant sets pend_vld=0.
  - Back-to-back reads are supported at one per cycle; rvalid follows gnt with exactly one cycle of delay.
- rdata is 0 when pend_vld=0.
- Write-then-read of the same index in consecutive cycles returns the new value, because the register file writes at the edge.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles.
- A request with req=0 is ignored regardless of its other fields.
- Reset asserted mid-read: the pending read is dropped and no rvalid is produced.

Optional Feature:
- RF_WRITE_PRIORITY_EN defined:
  - Any requester with req & req_we wins over all readers.
  - Round-robin from ptr applies among the writers only; ptr still advances to winner+1.
  - Readers can starve only while a write is pending every cycle.
- RF_WRITE_PRIORITY_EN undefined: pure round-robin, reads and writes treated equally.

Decomposition:
- Package rf_arb_pkg holds:
  - the DATA_W/ID_W defaults;
  - the op encoding constants OP_RD=1'b0 and OP_WR=1'b1;
  - a function clog2 for sizing ptr/pend_tag.
- One sub-module, rr_arbiter: parameter N; inputs req[N-1:0] and ptr; output one-hot gnt plus encoded winner. It is purely combinational.
- Pointer, pend register, muxing and the optional write-priority mask live in regfile_port_arbiter.

Test Plan:
1. Reset, then req=3'b000 -> gnt=0, rf_rd=rf_wn=0, rvalid=0, ptr stays 0.
2. Requester 2 writes id=5, data=0xBEEF; next cycle requester 0 reads id=5 -> gnt[2] in cycle 1, rf_wn=1; gnt[0] in cycle 2; cycle 3 shows rvalid=3'b001 and rdata=0xBEEF.
3. All three requesters hold reads (ids 1,2,3) for 6 cycles -> grant order 0,1,2,0,1,2; rvalid order delayed by one cycle; each rdata matches its register.
4. rst pulsed the cycle after requester 1's read grant -> rvalid stays 0, and the next grant after reset starts search at index 0.
5. With RF_WRITE_PRIORITY_EN, req=3'b111 with only requester 2 writing, ptr=0 -> gnt=3'b100 first, then 3'b001 on the next cycle once requester 2 drops req.
6. Single requester 1 issues reads on 4 consecutive cycles (ids 0..3 preloaded 0x10..0x13) -> rvalid[1] high for 4 cycles, rdata 0x10,0x11,0x12,0x13.
